// File: rtl/fc_rx_frame_checker_pkg.sv
// Shared FC receive-path definitions: CRC-32 constants and helper, checker state,
// error/counter indices and the ordered-set primitive decoder.
package fc_rx_frame_checker_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  localparam int ERR_CRC   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_DELIM = 2;

  localparam logic [2:0] ERR_TRUNC    = 3'b100;
  localparam logic [2:0] ERR_ONE_WORD = 3'b110;

  localparam int CNT_GOOD  = 0;
  localparam int CNT_CRC   = 1;
  localparam int CNT_LEN   = 2;
  localparam int CNT_DELIM = 3;
  localparam int CNT_DISC  = 4;
  localparam int CNT_NUM   = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_FRAME = 2'd1,
    ST_DISCARD  = 2'd2
  } checker_state_t;

  typedef enum logic [2:0] {
    PRIM_NONE,
    PRIM_EOFN,
    PRIM_EOFT,
    PRIM_EOFNI,
    PRIM_EOFA
  } prim_t;

  // K28.5 led EOF ordered sets, both running-disparity variants of the second byte
  function automatic prim_t map_primitive(input logic [31:0] word);
    prim_t p;
    p = PRIM_NONE;
    case (word)
      32'hBC95_D5D5, 32'hBCB5_D5D5: p = PRIM_EOFN;
      32'hBC95_7575, 32'hBCB5_7575: p = PRIM_EOFT;
      32'hBC8A_D5D5, 32'hBCAA_D5D5: p = PRIM_EOFNI;
      32'hBC95_B5B5, 32'hBCB5_B5B5: p = PRIM_EOFA;
      default:                      p = PRIM_NONE;
    endcase
    return p;
  endfunction

  // Bytes in order [31:24]..[7:0], each byte shifted in LSB first, MSB-first register
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] word);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = crc;
    for (int j = 3; j >= 0; j--) begin
      b = word[8*j +: 8];
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ b[i];
        c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/fc_crc32_word.sv
// Combinational next-CRC over one 32-bit word; shared by the RX checker and TX generator.
module fc_crc32_word
  import fc_rx_frame_checker_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [31:0] word_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_word(crc_i, word_i);

endmodule

// File: rtl/fc_rx_frame_checker.sv
// FC RX frame checker: validates CRC, length and EOF delimiter, forwards frames with
// one cycle of latency and keeps saturating status counters behind a CSR read port.
//
// state       | meaning
// ST_IDLE     | between frames, waiting for sop
// ST_IN_FRAME | forwarding a frame, accumulating CRC and word count
// ST_DISCARD  | dropping words of a frame cut short by a new sop, until eop
module fc_rx_frame_checker
  import fc_rx_frame_checker_pkg::*;
#(
  parameter int MTU       = 3072,
  parameter int MIN_WORDS = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [2:0]  out_error,
  output logic [1:0]  out_empty,
  input  logic [2:0]  csr_address,
  input  logic        csr_read,
  output logic [31:0] csr_readdata
);

  localparam int MAX_WORDS = MTU / 4;
  localparam int WC_W      = $clog2(MAX_WORDS + 2);
  localparam logic [WC_W-1:0] WC_SAT = WC_W'(MAX_WORDS + 1);

  checker_state_t state_q, state_d;
  logic [31:0]    crc_q, crc_d, crc_next;
  logic [WC_W-1:0] wcount_q, wcount_d;
  logic [WC_W:0]  wc_plus1;
  logic [CNT_NUM-1:0][31:0] cnt_q;
  logic [CNT_NUM-1:0] cnt_inc;

  logic [31:0] out_data_q, csr_q, csr_mux;
  logic        out_valid_q, out_valid_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [2:0]  out_error_q, out_error_d;

  prim_t       prim;
  logic        delim_ok;
  logic        len_bad;
  logic [2:0]  eop_err;

  fc_crc32_word u_crc (
    .crc_i  (crc_q),
    .word_i (in_data),
    .crc_o  (crc_next)
  );

  assign prim     = map_primitive(in_data);
  assign delim_ok = prim inside {PRIM_EOFN, PRIM_EOFT, PRIM_EOFNI};
  assign wc_plus1 = {1'b0, wcount_q} + 1'b1;
  assign len_bad  = (wc_plus1 < (WC_W+1)'(MIN_WORDS)) || (wc_plus1 > (WC_W+1)'(MAX_WORDS));
  assign eop_err  = {~delim_ok, len_bad, crc_q != CRC32_RESIDUE};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        ST_IN_FRAME: begin
          if (in_startofpacket)    state_d = ST_DISCARD;
          else if (in_endofpacket) state_d = ST_IDLE;
        end
        default: begin
          // IDLE and DISCARD react to a sop in the same way
          if (in_startofpacket)    state_d = in_endofpacket ? ST_IDLE : ST_IN_FRAME;
          else if (in_endofpacket) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_error_d = 3'b000;
    crc_d       = crc_q;
    wcount_d    = wcount_q;
    cnt_inc     = '0;
    if (in_valid) begin
      case (state_q)
        ST_IN_FRAME: begin
          out_valid_d = 1'b1;
          if (in_startofpacket) begin
            out_eop_d            = 1'b1;
            out_error_d          = ERR_TRUNC;
            cnt_inc[CNT_DELIM]   = 1'b1;
          end else if (in_endofpacket) begin
            out_eop_d            = 1'b1;
            out_error_d          = eop_err;
            cnt_inc[CNT_GOOD]    = (eop_err == 3'b000);
            cnt_inc[CNT_CRC]     = eop_err[ERR_CRC];
            cnt_inc[CNT_LEN]     = eop_err[ERR_LEN];
            cnt_inc[CNT_DELIM]   = eop_err[ERR_DELIM];
          end else begin
            crc_d = crc_next;
            if (wcount_q != WC_SAT) wcount_d = wcount_q + 1'b1;
          end
        end
        default: begin
          if (in_startofpacket) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            if (in_endofpacket) begin
              out_eop_d          = 1'b1;
              out_error_d        = ERR_ONE_WORD;
              cnt_inc[CNT_LEN]   = 1'b1;
              cnt_inc[CNT_DELIM] = 1'b1;
            end else begin
              crc_d    = CRC32_INIT;
              wcount_d = WC_W'(1);
            end
          end else begin
            cnt_inc[CNT_DISC] = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    csr_mux = 32'hFFFF_FFFF;
    case (csr_address)
      3'd0:    csr_mux = cnt_q[CNT_GOOD];
      3'd1:    csr_mux = cnt_q[CNT_CRC];
      3'd2:    csr_mux = cnt_q[CNT_LEN];
      3'd3:    csr_mux = cnt_q[CNT_DELIM];
      3'd4:    csr_mux = cnt_q[CNT_DISC];
      3'd5:    csr_mux = {30'd0, state_q};
      default: csr_mux = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q       <= CRC32_INIT;
      wcount_q    <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_error_q <= 3'b000;
      csr_q       <= '0;
    end else begin
      crc_q       <= crc_d;
      wcount_q    <= wcount_d;
      out_data_q  <= in_data;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_error_q <= out_error_d;
      for (int k = 0; k < CNT_NUM; k++) begin
        if (cnt_inc[k] && (cnt_q[k] != 32'hFFFF_FFFF)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
      if (csr_read) csr_q <= csr_mux;
    end
  end

  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_error         = out_error_q;
  assign out_empty         = 2'b00;
  assign csr_readdata      = csr_q;

endmodule

// File: tb/tb_fc_rx_frame_checker.sv
// Bench for fc_rx_frame_checker: directed and randomized frame segments checked against
// a frame-level reference model of forwarding, error codes and counters.
module tb_fc_rx_frame_checker;

  localparam logic [31:0] SOF_W   = 32'hBCB5_5656;
  localparam logic [31:0] EOFN_W  = 32'hBC95_D5D5;
  localparam logic [31:0] EOFT_W  = 32'hBC95_7575;
  localparam logic [31:0] EOFNI_W = 32'hBC8A_D5D5;
  localparam logic [31:0] EOFA_W  = 32'hBC95_B5B5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_startofpacket, in_endofpacket;
  logic [31:0] out_data;
  logic        out_valid, out_startofpacket, out_endofpacket;
  logic [2:0]  out_error;
  logic [1:0]  out_empty;
  logic [2:0]  csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned exp_cnt [5];
  int unsigned exp_state;

  always #5 clk = ~clk;

  fc_rx_frame_checker dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_error         (out_error),
    .out_empty         (out_empty),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_readdata      (csr_readdata)
  );

  // Reference CRC: the transmitted bit stream, byte [31:24] first, each byte LSB first
  function automatic logic [31:0] crc_model(logic [31:0] c, logic [31:0] w);
    logic [7:0] b;
    for (int j = 3; j >= 0; j--) begin
      b = w[8*j +: 8];
      for (int i = 0; i < 8; i++) begin
        if (c[31] ^ b[i]) c = (c << 1) ^ 32'h04C1_1DB7;
        else              c = c << 1;
      end
    end
    return c;
  endfunction

  // Complemented CRC placed so that register bit 31 is the first bit on the wire
  function automatic logic [31:0] fcs_word(logic [31:0] c);
    logic [31:0] w;
    logic [31:0] t;
    t = ~c;
    w = '0;
    for (int k = 0; k < 32; k++) w[24 - 8*(k/8) + (k%8)] = t[31-k];
    return w;
  endfunction

  function automatic bit good_eof(logic [31:0] w);
    return (w == EOFN_W) || (w == EOFT_W) || (w == EOFNI_W);
  endfunction

  task automatic check32(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(string tag, bit fwd, bit esop, bit eeop, logic [2:0] eerr, logic [31:0] d);
    logic [31:0] obs_ctl, exp_ctl;
    obs_ctl = {24'd0, out_valid, out_startofpacket, out_endofpacket, out_error, out_empty};
    exp_ctl = fwd ? {24'd0, 1'b1, esop, eeop, eerr, 2'b00} : 32'd0;
    check32({tag, " ctl"}, obs_ctl, exp_ctl);
    if (fwd) check32({tag, " data"}, out_data, d);
  endtask

  task automatic drive(string tag, logic [31:0] d, bit sop, bit eop, bit fwd, bit esop, bit eeop, logic [2:0] eerr);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_startofpacket = sop; in_endofpacket = eop; csr_read = 1'b0;
    @(posedge clk); #1;
    check_out(tag, fwd, esop, eeop, eerr, d);
  endtask

  task automatic gap(int n);
    for (int g = 0; g < n; g++) begin
      @(negedge clk);
      in_valid = 1'b0; in_data = $urandom; csr_read = 1'b0;
      in_startofpacket = 1'($urandom_range(0, 1)); in_endofpacket = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_out("gap", 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    end
  endtask

  task automatic csr_expect(string tag, logic [2:0] addr, logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    csr_read = 1'b1; csr_address = addr;
    @(posedge clk); #1;
    check32($sformatf("%s csr%0d", tag, addr), csr_readdata, exp);
  endtask

  task automatic check_all_csr(string tag);
    for (int a = 0; a < 5; a++) csr_expect(tag, 3'(a), exp_cnt[a]);
    csr_expect(tag, 3'd5, exp_state);
  endtask

  // force_err < 0: expected code from the model; otherwise a fixed expected code
  task automatic send_frame(string tag, int n, logic [31:0] eofw, bit with_fcs, bit corrupt, int g, int force_err);
    logic [31:0] body [$];
    logic [31:0] c, tmp;
    logic [2:0]  e;
    int          idx;
    body = {};
    for (int k = 0; k < n - 2; k++) body.push_back($urandom);
    if (with_fcs && n > 2) begin
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < n - 3; k++) c = crc_model(c, body[k]);
      body[n-3] = fcs_word(c);
    end
    if (corrupt && n > 2) begin
      idx = (n - 2 > 7) ? 6 : 0;
      tmp = body[idx]; tmp[0] = ~tmp[0]; body[idx] = tmp;
    end
    c = 32'hFFFF_FFFF;
    foreach (body[k]) c = crc_model(c, body[k]);
    e[0] = (c != 32'hC704_DD7B);
    e[1] = (n < 9) || (n > 768);
    e[2] = !good_eof(eofw);
    if (force_err >= 0) e = 3'(force_err);
    if (e == 3'b000) exp_cnt[0]++;
    else begin
      if (e[0]) exp_cnt[1]++;
      if (e[1]) exp_cnt[2]++;
      if (e[2]) exp_cnt[3]++;
    end
    drive({tag, " sof"}, SOF_W, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    foreach (body[k]) begin
      gap(g);
      drive({tag, " body"}, body[k], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    end
    gap(g);
    drive({tag, " eof"}, eofw, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, e);
    exp_state = 0;
  endtask

  task automatic send_trunc(string tag, int a, int b, bit close, bit second_eop);
    drive({tag, " sof"}, SOF_W, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    for (int k = 0; k < a; k++) drive({tag, " body"}, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    drive({tag, " cut"}, SOF_W, 1'b1, second_eop, 1'b1, 1'b0, 1'b1, 3'b100);
    exp_cnt[3]++;
    for (int k = 0; k < b; k++) begin
      drive({tag, " drop"}, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      exp_cnt[4]++;
    end
    exp_state = 2;
    if (close) begin
      drive({tag, " drop eof"}, EOFN_W, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      exp_cnt[4]++;
      exp_state = 0;
    end
  endtask

  task automatic send_stray(string tag, int k, bit allow_eop);
    bit eop;
    for (int i = 0; i < k; i++) begin
      eop = allow_eop && ($urandom_range(0, 3) == 0);
      drive(tag, $urandom, 1'b0, eop, 1'b0, 1'b0, 1'b0, 3'b000);
      exp_cnt[4]++;
      if (eop) exp_state = 0;
    end
  endtask

  task automatic send_one_word(string tag);
    drive(tag, $urandom, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b110);
    exp_cnt[2]++;
    exp_cnt[3]++;
    exp_state = 0;
  endtask

  function automatic logic [31:0] pick_eof();
    case ($urandom_range(0, 5))
      0, 1:    return EOFN_W;
      2:       return EOFT_W;
      3:       return EOFNI_W;
      4:       return EOFA_W;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    csr_read = 1'b0; csr_address = 3'd0;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    exp_state = 0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    check32("reset csr_readdata", csr_readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check_all_csr("reset");
    csr_expect("unmapped", 3'd6, 32'hFFFF_FFFF);
    csr_expect("unmapped", 3'd7, 32'hFFFF_FFFF);
    @(negedge clk);
    csr_read = 1'b0; csr_address = 3'd0;
    @(posedge clk); #1;
    check32("csr hold", csr_readdata, 32'hFFFF_FFFF);

    send_frame("good13", 13, EOFN_W, 1'b1, 1'b0, 0, 0);
    check_all_csr("good13");
    send_frame("crcflip", 13, EOFN_W, 1'b1, 1'b1, 0, 1);
    check_all_csr("crcflip");
    send_frame("short5", 5, EOFN_W, 1'b0, 1'b0, 0, 3);
    send_frame("eofa9", 9, EOFA_W, 1'b1, 1'b0, 0, 4);
    check_all_csr("short_eofa");

    send_frame("min9", 9, EOFN_W, 1'b1, 1'b0, 0, 0);
    send_frame("len8", 8, EOFT_W, 1'b1, 1'b0, 0, 2);
    send_frame("max768", 768, EOFNI_W, 1'b1, 1'b0, 0, 0);
    send_frame("len769", 769, EOFN_W, 1'b1, 1'b0, 0, 2);
    send_frame("len800", 800, EOFN_W, 1'b1, 1'b0, 0, 2);
    check_all_csr("lengths");

    send_trunc("trunc", 3, 5, 1'b1, 1'b0);
    check_all_csr("trunc");

    drive("st sof", SOF_W, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    drive("st body", $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    csr_expect("st in_frame", 3'd5, 32'd1);
    drive("st cut", SOF_W, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100);
    exp_cnt[3]++;
    csr_expect("st discard", 3'd5, 32'd2);
    drive("st drop", EOFN_W, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    exp_cnt[4]++;
    exp_state = 0;
    check_all_csr("st idle");

    send_stray("stray", 3, 1'b0);
    send_frame("gapped", 13, EOFN_W, 1'b1, 1'b0, 2, 0);
    check_all_csr("gapped");
    send_one_word("oneword");
    check_all_csr("oneword");

    drive("rst sof", SOF_W, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 3; k++) drive("rst body", $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = EOFN_W; in_startofpacket = 1'b0; in_endofpacket = 1'b1;
    @(posedge clk); #1;
    check_out("rst cycle", 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    exp_state = 0;
    drive("rst tail", EOFN_W, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    exp_cnt[4]++;
    gap(2);
    check_all_csr("after reset");
    send_frame("post rst", 13, EOFN_W, 1'b1, 1'b0, 1, 0);
    check_all_csr("post rst");

    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 5))
        0, 1: send_frame("rnd frame", $urandom_range(9, 40), pick_eof(), 1'b1,
                         ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1);
        2:    send_frame("rnd odd", $urandom_range(2, 12), pick_eof(), 1'($urandom_range(0, 1)),
                         1'b0, $urandom_range(0, 1), -1);
        3:    send_stray("rnd stray", $urandom_range(1, 4), 1'b1);
        4:    send_trunc("rnd trunc", $urandom_range(0, 5), $urandom_range(0, 4),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: send_one_word("rnd oneword");
      endcase
      if (s % 10 == 9) check_all_csr("rnd");
    end
    check_all_csr("final");
    csr_expect("final unmapped", 3'd7, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
